sccb_responder: RTL and testbench
=================================

// Module: sccb_responder
// PURPOSE
//  SCCB target (camera-side) model: the responding end of the SCCB master that
//  configures the OV camera over scl/sda. Oversamples scl/sda on clk, decodes
//  START/STOP, 3-phase writes and 2-phase reads, and keeps a register file.
//  ACKs the master's bytes and returns register contents on reads.
//  Used as a loopback target on the board and as the bench model for the master.
// PARAMETERS
//  DEV_ID   7'h21  7-bit device address (write ID byte 0x42, read ID byte 0x43)
//  ADDR_W   8      register sub-address width; file depth 2**ADDR_W x 8 bit
// PORTS
//  clk          in   1       system clock; must be >= 8x scl frequency
//  rst          in   1       synchronous active-high reset
//  scl          in   1       SCCB clock from master (async)
//  sda_in       in   1       SCCB data line as seen on the pad (async)
//  sda_oe       out  1       1 = pull sda low; pad is open-drain, never drive 1
//  wr_en        out  1       1-cycle pulse on each committed register write
//  wr_addr      out  ADDR_W  sub-address of the committed write
//  wr_data      out  8       data of the committed write
//  host_addr    in   ADDR_W  local read port address (debug / 7-seg)
//  host_data    out  8       reg[host_addr], combinational
//  busy         out  1       1 from START until STOP or abort
// BEHAVIOUR
//  - Input path: scl, sda_in each pass 2-flop sync, then 1 history flop; edges
//    detected on synced values. Total detect latency 3 clk cycles.
//  - START: sda fall while scl high. STOP: sda rise while scl high. Both valid in
//    any state; START (incl. repeated) -> ID, bit_cnt=0; STOP -> IDLE.
//  - Bits sampled on scl rise; sda_oe changes only on scl fall (after edge detect).
//  - States: IDLE, ID, ID_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RD_NA, IGNORE.
//  - ID: shift 8 bits MSB first. On 8th scl fall: ID[7:1]==DEV_ID -> ID_ACK,
//    sda_oe=1; else -> IGNORE, sda_oe stays 0 (no ACK, no side effects).
//  - x_ACK: hold sda_oe=1 through 9th scl high; release on 9th scl fall, then
//    ID_ACK -> SUB (R/W=0) or RDATA (R/W=1, first bit driven same fall);
//    SUB_ACK -> WDATA; WDATA_ACK -> WDATA.
//  - SUB: 8 bits -> sub_addr (low ADDR_W bits kept), ACK. Sub-address persists
//    across STOP for a later 2-phase read.
//  - WDATA: 8 bits -> reg[sub_addr] written on 8th scl fall; wr_en pulses that
//    cycle with wr_addr/wr_data; then ACK; sub_addr increments, wraps max->0.
//  - RDATA: sda_oe = ~reg[sub_addr][7-bit_cnt], updated on each scl fall; after
//    8th bit release (sda_oe=0) -> RD_NA. RD_NA samples master bit on 9th rise:
//    1 (NA) -> IGNORE; 0 (ACK) -> sub_addr+1, RDATA next byte.
//  - IGNORE: sda_oe=0, waits for STOP or START.
//  - Reset values: state IDLE, sda_oe 0, wr_en 0, wr_addr 0, wr_data 0, busy 0,
//    sub_addr 0, all register file entries 0x00. Reset mid-transfer releases sda
//    next cycle and discards the partial byte (no write).
//  - START/STOP in mid-byte: partial byte discarded, no wr_en.
//  - sda_in while sda_oe=1 is not checked (own pull-down).
// TESTING
//  1 Write 0x42,0x12,0x80,STOP -> ACK low on 3 9th clocks; wr_en once,
//    wr_addr=0x12, wr_data=0x80; host_addr=0x12 -> host_data=0x80.
//  2 Write 0x60,0x12,0x55 -> sda_oe never 1, no wr_en, reg[0x12] unchanged.
//  3 After 1: 0x42,0x12,STOP; START,0x43 -> ACK, sda bits 1000_0000, master NA,
//    STOP -> busy 0, sda_oe 0.
//  4 Write 0x42,0xFF,0xA1,0xB2 -> reg[0xFF]=0xA1, reg[0x00]=0xB2 (wrap).
//  5 rst asserted during 5th data bit of 0x42,0x30,0x77 -> sda_oe 0 next cycle,
//    no wr_en, all regs 0x00; next full write succeeds.
//  6 Repeated START after 3 bits of sub-address, then 0x42,0x05,0x09 ->
//    only write reg[0x05]=0x09.

Source files
------------

// File: rtl/sccb_responder.sv
// rtl/sccb_responder.sv - SCCB target: decodes START/STOP, 3-phase writes and 2-phase reads over scl/sda
// Keeps a 2**ADDR_W x 8 register file, ACKs matching-ID transfers and serves reads.
module sccb_responder #(
  parameter logic [6:0] DEV_ID = 7'h21,
  parameter int         ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] host_addr,
  output logic [7:0]        host_data,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [3:0] {
    S_IDLE, S_ID, S_ID_ACK, S_SUB, S_SUB_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RD_NA, S_IGNORE
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          scl_sync_q, sda_sync_q;
  logic                scl_hist_q, sda_hist_q;
  logic [3:0]          cnt_q, cnt_d;
  logic [7:0]          shift_q, shift_d;
  logic                oe_q, oe_d;
  logic                rw_q, rw_d;
  logic                rd_ack_q, rd_ack_d;
  logic [ADDR_W-1:0]   sub_q, sub_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]          wr_data_q, wr_data_d;
  logic                mem_we;
  logic [7:0]          mem_q [DEPTH];
  logic [2:0]          rd_idx;

  // Synchronisers carry no reset so a reset mid-transfer cannot fabricate a bus edge.
  always_ff @(posedge clk) begin
    scl_sync_q <= {scl_sync_q[0], scl};
    sda_sync_q <= {sda_sync_q[0], sda_in};
    scl_hist_q <= scl_sync_q[1];
    sda_hist_q <= sda_sync_q[1];
  end

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = scl_s & ~scl_hist_q;
  assign scl_fall  = ~scl_s & scl_hist_q;
  assign start_det = scl_s & scl_hist_q & ~sda_s & sda_hist_q;
  assign stop_det  = scl_s & scl_hist_q & sda_s & ~sda_hist_q;

  assign rd_idx = 3'd7 - cnt_q[2:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    oe_d      = oe_q;
    rw_d      = rw_q;
    rd_ack_d  = rd_ack_q;
    sub_d     = sub_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    mem_we    = 1'b0;
    if (start_det) begin
      state_d  = S_ID;
      cnt_d    = 4'd0;
      oe_d     = 1'b0;
      rd_ack_d = 1'b0;
    end else if (stop_det) begin
      state_d = S_IDLE;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        S_ID, S_SUB, S_WDATA: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            if (state_q == S_ID) begin
              if (shift_q[7:1] == DEV_ID) begin
                state_d = S_ID_ACK;
                oe_d    = 1'b1;
                rw_d    = shift_q[0];
              end else begin
                state_d = S_IGNORE;
              end
            end else if (state_q == S_SUB) begin
              sub_d   = shift_q[ADDR_W-1:0];
              state_d = S_SUB_ACK;
              oe_d    = 1'b1;
            end else begin
              mem_we    = 1'b1;
              wr_en_d   = 1'b1;
              wr_addr_d = sub_q;
              wr_data_d = shift_q;
              sub_d     = sub_q + 1'b1;
              state_d   = S_WDATA_ACK;
              oe_d      = 1'b1;
            end
          end
        end
        S_ID_ACK: begin
          if (scl_fall) begin
            cnt_d = 4'd0;
            if (rw_q) begin
              state_d = S_RDATA;
              oe_d    = ~mem_q[sub_q][7];
            end else begin
              state_d = S_SUB;
              oe_d    = 1'b0;
            end
          end
        end
        S_SUB_ACK, S_WDATA_ACK: begin
          if (scl_fall) begin
            state_d = S_WDATA;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
          end
        end
        S_RDATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              state_d  = S_RD_NA;
              oe_d     = 1'b0;
              rd_ack_d = 1'b0;
            end else begin
              oe_d = ~mem_q[sub_q][rd_idx];
            end
          end
        end
        S_RD_NA: begin
          // Master ACK advances the address on the rise; next byte starts driving on the fall.
          if (scl_rise) begin
            if (sda_s) begin
              state_d = S_IGNORE;
            end else begin
              sub_d    = sub_q + 1'b1;
              rd_ack_d = 1'b1;
            end
          end else if (scl_fall && rd_ack_q) begin
            state_d  = S_RDATA;
            cnt_d    = 4'd0;
            rd_ack_d = 1'b0;
            oe_d     = ~mem_q[sub_q][7];
          end
        end
        default: oe_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      shift_q   <= 8'h00;
      oe_q      <= 1'b0;
      rw_q      <= 1'b0;
      rd_ack_q  <= 1'b0;
      sub_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      oe_q      <= oe_d;
      rw_q      <= rw_d;
      rd_ack_q  <= rd_ack_d;
      sub_q     <= sub_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else if (mem_we) begin
      mem_q[sub_q] <= shift_q;
    end
  end

  assign sda_oe    = oe_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign host_data = mem_q[host_addr];
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_sccb_responder.sv
// tb/tb_sccb_responder.sv - directed SCCB master bench for sccb_responder
// Drives scl/sda as an open-drain master and checks ACKs, writes, reads and reset behaviour.
module tb_sccb_responder;

  localparam int Q = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe, wr_en, busy;
  logic [7:0] wr_addr, wr_data, host_addr, host_data;

  int         n_tests = 0;
  int         n_fail = 0;
  int         wr_cnt = 0;
  int         oe_cnt = 0;
  logic [7:0] last_a = 8'h00;
  logic [7:0] last_d = 8'h00;

  assign sda_line = sda_m & ~sda_oe;

  sccb_responder #(.DEV_ID(7'h21), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda_in(sda_line), .sda_oe(sda_oe),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .host_addr(host_addr), .host_data(host_data), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_en) begin
      wr_cnt <= wr_cnt + 1;
      last_a <= wr_addr;
      last_d <= wr_data;
    end
    if (sda_oe) oe_cnt <= oe_cnt + 1;
  end

  task automatic wt(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_c();
    sda_m = 1'b1; wt(Q); scl = 1'b1; wt(Q); sda_m = 1'b0; wt(Q); scl = 1'b0; wt(Q);
  endtask

  task automatic stop_c();
    sda_m = 1'b0; wt(Q); scl = 1'b1; wt(Q); sda_m = 1'b1; wt(2 * Q);
  endtask

  task automatic wbits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      sda_m = b[7 - i]; wt(Q); scl = 1'b1; wt(2 * Q); scl = 1'b0; wt(Q);
    end
  endtask

  task automatic ack9(output logic a);
    sda_m = 1'b1; wt(Q); scl = 1'b1; wt(Q); a = sda_line; wt(Q); scl = 1'b0; wt(Q);
  endtask

  task automatic wbyte(input logic [7:0] b, output logic a);
    wbits(b, 8);
    ack9(a);
  endtask

  task automatic rbyte(output logic [7:0] d);
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      sda_m = 1'b1; wt(Q); scl = 1'b1; wt(Q); d = {d[6:0], sda_line}; wt(Q); scl = 1'b0; wt(Q);
    end
  endtask

  task automatic mack9(input logic na);
    sda_m = na; wt(Q); scl = 1'b1; wt(2 * Q); scl = 1'b0; wt(Q);
  endtask

  task automatic peek(input logic [7:0] a, input string tag, input logic [7:0] exp);
    host_addr = a;
    wt(1);
    check(tag, 32'(host_data), 32'(exp));
  endtask

  initial begin
    logic       a0, a1, a2, a3;
    logic [7:0] d0, d1;
    int         w0, o0;
    host_addr = 8'h12;
    wt(5);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_reg12", 32'(host_data), 32'd0);
    rst = 1'b0;
    wt(5);

    // 1: plain 3-phase write
    w0 = wr_cnt;
    start_c();
    check("t1_busy", 32'(busy), 32'd1);
    wbyte(8'h42, a0); wbyte(8'h12, a1); wbyte(8'h80, a2);
    stop_c();
    check("t1_acks", 32'({a0, a1, a2}), 32'd0);
    check("t1_wr_cnt", 32'(wr_cnt - w0), 32'd1);
    check("t1_wr_addr", 32'(last_a), 32'h12);
    check("t1_wr_data", 32'(last_d), 32'h80);
    peek(8'h12, "t1_reg12", 8'h80);
    check("t1_busy_end", 32'(busy), 32'd0);

    // 2: foreign ID is ignored
    w0 = wr_cnt; o0 = oe_cnt;
    start_c();
    wbyte(8'h60, a0); wbyte(8'h12, a1); wbyte(8'h55, a2);
    stop_c();
    check("t2_noack", 32'({a0, a1, a2}), 32'h7);
    check("t2_oe_cnt", 32'(oe_cnt - o0), 32'd0);
    check("t2_wr_cnt", 32'(wr_cnt - w0), 32'd0);
    peek(8'h12, "t2_reg12", 8'h80);

    // 3: 2-phase read with master NA
    start_c(); wbyte(8'h42, a0); wbyte(8'h12, a1); stop_c();
    start_c(); wbyte(8'h43, a2);
    rbyte(d0);
    mack9(1'b1);
    stop_c();
    check("t3_acks", 32'({a0, a1, a2}), 32'd0);
    check("t3_rdata", 32'(d0), 32'h80);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_sda_oe", 32'(sda_oe), 32'd0);

    // 4: burst write wrapping 0xFF -> 0x00, then burst read across the wrap
    w0 = wr_cnt;
    start_c(); wbyte(8'h42, a0); wbyte(8'hFF, a1); wbyte(8'hA1, a2); wbyte(8'hB2, a3); stop_c();
    check("t4_acks", 32'({a0, a1, a2, a3}), 32'd0);
    check("t4_wr_cnt", 32'(wr_cnt - w0), 32'd2);
    peek(8'hFF, "t4_regFF", 8'hA1);
    peek(8'h00, "t4_reg00", 8'hB2);
    start_c(); wbyte(8'h42, a0); wbyte(8'hFF, a1); stop_c();
    start_c(); wbyte(8'h43, a2);
    rbyte(d0); mack9(1'b0); rbyte(d1); mack9(1'b1);
    stop_c();
    check("t4_rd0", 32'(d0), 32'hA1);
    check("t4_rd1", 32'(d1), 32'hB2);

    // 5a: reset while the ID ACK is being driven releases sda next cycle
    start_c(); wbits(8'h42, 8);
    sda_m = 1'b1; wt(Q); scl = 1'b1; wt(Q);
    check("t5a_oe_before", 32'(sda_oe), 32'd1);
    rst = 1'b1; wt(1); rst = 1'b0;
    check("t5a_oe_after", 32'(sda_oe), 32'd0);
    wt(Q); scl = 1'b0; wt(Q);
    stop_c();

    // 5b: reset during 5th data bit discards the byte and clears the file
    w0 = wr_cnt;
    start_c(); wbyte(8'h42, a0); wbyte(8'h30, a1); wbits(8'h77, 4);
    sda_m = 1'b0; wt(Q); scl = 1'b1; wt(Q);
    rst = 1'b1; wt(1); rst = 1'b0;
    check("t5_oe", 32'(sda_oe), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    wt(Q); scl = 1'b0; wt(Q);
    wbits(8'hE0, 3);
    stop_c();
    check("t5_wr_cnt", 32'(wr_cnt - w0), 32'd0);
    peek(8'h12, "t5_reg12", 8'h00);
    peek(8'hFF, "t5_regFF", 8'h00);
    peek(8'h00, "t5_reg00", 8'h00);
    w0 = wr_cnt;
    start_c(); wbyte(8'h42, a0); wbyte(8'h30, a1); wbyte(8'h77, a2); stop_c();
    check("t5_acks", 32'({a0, a1, a2}), 32'd0);
    check("t5_wr_cnt2", 32'(wr_cnt - w0), 32'd1);
    peek(8'h30, "t5_reg30", 8'h77);

    // 6: repeated START after 3 sub-address bits
    w0 = wr_cnt;
    start_c(); wbyte(8'h42, a0); wbits(8'h12, 3);
    start_c(); wbyte(8'h42, a1); wbyte(8'h05, a2); wbyte(8'h09, a3); stop_c();
    check("t6_acks", 32'({a0, a1, a2, a3}), 32'd0);
    check("t6_wr_cnt", 32'(wr_cnt - w0), 32'd1);
    check("t6_wr_addr", 32'(last_a), 32'h05);
    check("t6_wr_data", 32'(last_d), 32'h09);
    peek(8'h05, "t6_reg05", 8'h09);
    peek(8'h12, "t6_reg12", 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
